gray_sobel_frame_sequencer: RTL and testbench

Frame-level controller for the grayscale/Sobel datapath. It sits between the SPI pixel interface and the `top_gray_sobel` core. It accepts a frame request and latches the processing mode. It issues the core start pulse, admits exactly IMG_WIDTH×IMG_HEIGHT input pixels with row/column tracking, and collects the core's output-pixel strobes into a valid/ready stream. It then signals frame completion, timeout or overrun.

---
 rtl/gray_sobel_frame_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_gray_sobel_frame_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_sobel_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : gray_sobel_frame_sequencer
//  Purpose  : Frame-level controller between the SPI pixel interface and the
//             grayscale/Sobel core. Latches the processing mode, pulses the
//             core start, admits exactly IMG_WIDTH*IMG_HEIGHT input pixels
//             with row/column tracking, turns core output strobes into a
//             valid/ready stream and reports done / timeout / overrun.
//  Ports    : clk_i, reset_i (async, active-high)
//             cfg_select_i, frame_start_i, abort_i      - frame control
//             in_px_valid_i / in_px_ready_o             - input pixel accept
//             core_start_o, core_select_o               - core control
//             core_px_ready_i                           - core output strobe
//             out_px_valid_o / out_px_ready_i           - output stream
//             row_o, col_o                              - next input position
//             busy_o, done_o, timeout_o, overrun_o      - status
//  Revision : 1.0 - initial release
// ============================================================================
module gray_sobel_frame_sequencer #(
   parameter int IMG_WIDTH     = 16,
   parameter int IMG_HEIGHT    = 16,
   parameter int DRAIN_TIMEOUT = 1024
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [1:0]                    cfg_select_i,
   input  logic                          frame_start_i,
   input  logic                          abort_i,
   input  logic                          in_px_valid_i,
   output logic                          in_px_ready_o,
   output logic                          core_start_o,
   output logic [1:0]                    core_select_o,
   input  logic                          core_px_ready_i,
   output logic                          out_px_valid_o,
   input  logic                          out_px_ready_i,
   output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
   output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          timeout_o,
   output logic                          overrun_o
);

   localparam int c_cnt_w   = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);
   localparam int c_drain_w = $clog2(DRAIN_TIMEOUT);
   localparam int c_row_w   = $clog2(IMG_HEIGHT);
   localparam int c_col_w   = $clog2(IMG_WIDTH);

   localparam logic [c_cnt_w-1:0]   c_total      = c_cnt_w'(IMG_WIDTH * IMG_HEIGHT);
   localparam logic [c_cnt_w-1:0]   c_last_px    = c_cnt_w'(IMG_WIDTH * IMG_HEIGHT - 1);
   localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(DRAIN_TIMEOUT - 1);
   localparam logic [c_row_w-1:0]   c_row_last   = c_row_w'(IMG_HEIGHT - 1);
   localparam logic [c_col_w-1:0]   c_col_last   = c_col_w'(IMG_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                 state_q,     state_d;
   logic [1:0]             sel_q,       sel_d;
   logic [c_cnt_w-1:0]     in_cnt_q,    in_cnt_d;
   logic [c_cnt_w-1:0]     out_cnt_q,   out_cnt_d;
   logic [c_drain_w-1:0]   drain_cnt_q, drain_cnt_d;
   logic [c_row_w-1:0]     row_q,       row_d;
   logic [c_col_w-1:0]     col_q,       col_d;
   logic                   out_valid_q, out_valid_d;
   logic                   timeout_q,   timeout_d;
   logic                   overrun_q,   overrun_d;
   logic                   start_q,     start_d;
   logic                   busy_q,      busy_d;
   logic                   done_q,      done_d;

   logic                   w_in_ready;
   logic                   w_accept;
   logic                   w_strobe;
   logic                   w_out_complete;

   // Ready depends only on state and count, never on in_px_valid_i.
   assign w_in_ready = (state_q == S_STREAM) && (in_cnt_q < c_total);
   assign w_accept   = in_px_valid_i && w_in_ready;
   assign w_strobe   = core_px_ready_i && ((state_q == S_STREAM) || (state_q == S_DRAIN));

   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      in_cnt_d       = in_cnt_q;
      out_cnt_d      = out_cnt_q;
      drain_cnt_d    = drain_cnt_q;
      row_d          = row_q;
      col_d          = col_q;
      out_valid_d    = out_valid_q;
      timeout_d      = timeout_q;
      overrun_d      = overrun_q;
      w_out_complete = 1'b0;

      // Output path: a new strobe always wins over a same-cycle handshake.
      if (w_strobe) begin
         out_valid_d = 1'b1;
         if (out_valid_q && !out_px_ready_i) begin
            overrun_d = 1'b1;
         end
         if (out_cnt_q != c_total) begin
            out_cnt_d = out_cnt_q + 1'b1;
         end
      end else if (out_valid_q && out_px_ready_i) begin
         out_valid_d = 1'b0;
      end

      // Completion looks at the post-update count so it can finish this cycle.
      w_out_complete = (out_cnt_d == c_total);

      case (state_q)
         S_IDLE: begin
            if (frame_start_i && !abort_i) begin
               sel_d       = cfg_select_i;
               in_cnt_d    = '0;
               out_cnt_d   = '0;
               drain_cnt_d = '0;
               row_d       = '0;
               col_d       = '0;
               timeout_d   = 1'b0;
               overrun_d   = 1'b0;
               state_d     = S_ARM;
            end
         end
         S_ARM: begin
            state_d = S_STREAM;
         end
         S_STREAM: begin
            if (w_accept) begin
               in_cnt_d = in_cnt_q + 1'b1;
               if (col_q == c_col_last) begin
                  col_d = '0;
                  row_d = (row_q == c_row_last) ? '0 : row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               if (in_cnt_q == c_last_px) begin
                  state_d = w_out_complete ? S_DONE : S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            drain_cnt_d = drain_cnt_q + 1'b1;
            if (w_out_complete) begin
               state_d = S_DONE;
            end else if (drain_cnt_q == c_drain_last) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides every other transition outside IDLE.
      if (abort_i && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         in_cnt_d    = '0;
         out_cnt_d   = '0;
         drain_cnt_d = '0;
         row_d       = '0;
         col_d       = '0;
         out_valid_d = 1'b0;
      end

      // Status outputs are registered copies of the next-state decode.
      start_d = (state_d == S_ARM);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         drain_cnt_q <= '0;
         row_q       <= '0;
         col_q       <= '0;
         out_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         overrun_q   <= 1'b0;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         row_q       <= row_d;
         col_q       <= col_d;
         out_valid_q <= out_valid_d;
         timeout_q   <= timeout_d;
         overrun_q   <= overrun_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_px_ready_o  = w_in_ready;
   assign core_start_o   = start_q;
   assign core_select_o  = sel_q;
   assign out_px_valid_o = out_valid_q;
   assign row_o          = row_q;
   assign col_o          = col_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign timeout_o      = timeout_q;
   assign overrun_o      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_sobel_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gray_sobel_frame_sequencer
//  Purpose  : Self-checking bench for gray_sobel_frame_sequencer (4x3 frame,
//             drain timeout 64). Row/column vectors come from a table; core
//             output strobes are tracked in a scoreboard queue and retired on
//             each output handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gray_sobel_frame_sequencer;

   localparam int W     = 4;
   localparam int H     = 3;
   localparam int TOTAL = W * H;
   localparam int DT    = 64;
   localparam int LAT   = 3;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [1:0] cfg_select_i;
   logic       frame_start_i;
   logic       abort_i;
   logic       in_px_valid_i;
   logic       in_px_ready_o;
   logic       core_start_o;
   logic [1:0] core_select_o;
   logic       core_px_ready_i;
   logic       out_px_valid_o;
   logic       out_px_ready_i;
   logic [1:0] row_o;
   logic [1:0] col_o;
   logic       busy_o;
   logic       done_o;
   logic       timeout_o;
   logic       overrun_o;

   always #5 clk_i = ~clk_i;

   gray_sobel_frame_sequencer #(
      .IMG_WIDTH     (W),
      .IMG_HEIGHT    (H),
      .DRAIN_TIMEOUT (DT)
   ) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .cfg_select_i    (cfg_select_i),
      .frame_start_i   (frame_start_i),
      .abort_i         (abort_i),
      .in_px_valid_i   (in_px_valid_i),
      .in_px_ready_o   (in_px_ready_o),
      .core_start_o    (core_start_o),
      .core_select_o   (core_select_o),
      .core_px_ready_i (core_px_ready_i),
      .out_px_valid_o  (out_px_valid_o),
      .out_px_ready_i  (out_px_ready_i),
      .row_o           (row_o),
      .col_o           (col_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .timeout_o       (timeout_o),
      .overrun_o       (overrun_o)
   );

   typedef struct {
      logic valid;
      int   exp_row;
      int   exp_col;
   } vec_t;

   vec_t vecs [TOTAL];

   int total     = 0;
   int bad       = 0;
   int cyc       = 0;
   int done_cnt  = 0;
   int start_cnt = 0;
   int hs_cnt    = 0;
   bit auto_strobe  = 1'b0;
   bit force_strobe = 1'b0;
   int sched [$];
   int exp_q [$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive due strobes, retire handshakes, advance.
   task automatic tick();
      logic s;
      s = force_strobe;
      if (sched.size() > 0 && sched[0] == cyc) begin
         s = 1'b1;
         void'(sched.pop_front());
      end
      core_px_ready_i = s;
      if (s) exp_q.push_back(cyc);
      if (out_px_valid_o && out_px_ready_i) begin
         hs_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL handshake_without_strobe: got handshake expected none (cycle %0d)", cyc);
         end else begin
            void'(exp_q.pop_front());
         end
      end
      if (auto_strobe && in_px_valid_i && in_px_ready_o) sched.push_back(cyc + LAT);
      @(posedge clk_i);
      #1;
      cyc++;
      core_px_ready_i = 1'b0;
      force_strobe    = 1'b0;
      if (done_o)       done_cnt++;
      if (core_start_o) start_cnt++;
   endtask

   task automatic start_frame(input logic [1:0] cfg);
      cfg_select_i  = cfg;
      frame_start_i = 1'b1;
      tick();
      frame_start_i = 1'b0;
   endtask

   task automatic do_abort();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
   endtask

   // Full frame through the vector table, then wait for done_o.
   task automatic run_frame(input logic [1:0] cfg, input bit auto_s, input int exp_delay, input string tag);
      int m;
      int n;
      int d0;
      int s0;
      auto_strobe   = auto_s;
      in_px_valid_i = 1'b0;
      d0 = done_cnt;
      s0 = start_cnt;
      m  = 0;
      start_frame(cfg);
      chk({tag, "_core_start"}, int'(core_start_o), 1);
      chk({tag, "_core_select"}, int'(core_select_o), int'(cfg));
      chk({tag, "_arm_ready"}, int'(in_px_ready_o), 0);
      cfg_select_i = ~cfg;
      tick();
      chk({tag, "_start_width"}, int'(core_start_o), 0);
      for (int i = 0; i < TOTAL; i++) begin
         chk({tag, "_row"}, int'(row_o), vecs[i].exp_row);
         chk({tag, "_col"}, int'(col_o), vecs[i].exp_col);
         chk({tag, "_ready"}, int'(in_px_ready_o), 1);
         in_px_valid_i = vecs[i].valid;
         m = cyc;
         tick();
      end
      in_px_valid_i = 1'b0;
      chk({tag, "_ready_after_last"}, int'(in_px_ready_o), 0);
      n = 0;
      while (!done_o && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_done_latency"}, done_o ? (cyc - m) : -1, exp_delay);
      chk({tag, "_timeout"}, int'(timeout_o), auto_s ? 0 : 1);
      chk({tag, "_overrun"}, int'(overrun_o), 0);
      chk({tag, "_final_row"}, int'(row_o), 0);
      chk({tag, "_final_col"}, int'(col_o), 0);
      chk({tag, "_select_held"}, int'(core_select_o), int'(cfg));
      chk({tag, "_start_count"}, start_cnt - s0, 1);
      tick();
      chk({tag, "_busy_fall"}, int'(busy_o), 0);
      chk({tag, "_done_count"}, done_cnt - d0, 1);
      chk({tag, "_scoreboard_empty"}, exp_q.size(), 0);
      auto_strobe = 1'b0;
   endtask

   initial begin
      int d0;
      int s0;
      int h0;
      for (int i = 0; i < TOTAL; i++) begin
         vecs[i].valid   = 1'b1;
         vecs[i].exp_row = i / W;
         vecs[i].exp_col = i % W;
      end

      reset_i         = 1'b1;
      cfg_select_i    = 2'b00;
      frame_start_i   = 1'b0;
      abort_i         = 1'b0;
      in_px_valid_i   = 1'b0;
      core_px_ready_i = 1'b0;
      out_px_ready_i  = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_done", int'(done_o), 0);
      chk("rst_core_start", int'(core_start_o), 0);
      chk("rst_core_select", int'(core_select_o), 0);
      chk("rst_row", int'(row_o), 0);
      chk("rst_col", int'(col_o), 0);
      chk("rst_in_ready", int'(in_px_ready_o), 0);
      chk("rst_out_valid", int'(out_px_valid_o), 0);
      chk("rst_timeout", int'(timeout_o), 0);
      chk("rst_overrun", int'(overrun_o), 0);
      reset_i = 1'b0;
      tick();

      // Normal frame, sobel mode, core strobes 3 cycles after each accept.
      h0 = hs_cnt;
      run_frame(2'b10, 1'b1, LAT + 1, "t1");
      chk("t1_handshakes", hs_cnt - h0, TOTAL);

      // No core strobes: drain must time out.
      run_frame(2'b11, 1'b0, DT + 1, "t2");

      // Two strobes under backpressure.
      start_frame(2'b01);
      tick();
      chk("t3_timeout_cleared", int'(timeout_o), 0);
      out_px_ready_i = 1'b0;
      force_strobe   = 1'b1;
      tick();
      chk("t3_valid_first", int'(out_px_valid_o), 1);
      chk("t3_no_overrun_first", int'(overrun_o), 0);
      force_strobe = 1'b1;
      tick();
      chk("t3_overrun", int'(overrun_o), 1);
      chk("t3_valid_second", int'(out_px_valid_o), 1);
      tick();
      chk("t3_valid_held", int'(out_px_valid_o), 1);
      out_px_ready_i = 1'b1;
      tick();
      chk("t3_valid_taken", int'(out_px_valid_o), 0);
      do_abort();
      chk("t3_abort_busy", int'(busy_o), 0);
      exp_q.delete();

      // Strobe coinciding with a handshake, then mid-frame start/cfg change.
      start_frame(2'b11);
      tick();
      chk("t4_overrun_cleared", int'(overrun_o), 0);
      force_strobe = 1'b1;
      tick();
      chk("t4_valid", int'(out_px_valid_o), 1);
      force_strobe = 1'b1;
      tick();
      chk("t4_valid_coincide", int'(out_px_valid_o), 1);
      chk("t4_no_overrun", int'(overrun_o), 0);
      tick();
      chk("t4_valid_drained", int'(out_px_valid_o), 0);
      chk("t4_scoreboard_empty", exp_q.size(), 0);
      s0 = start_cnt;
      cfg_select_i  = 2'b01;
      frame_start_i = 1'b1;
      tick();
      frame_start_i = 1'b0;
      tick();
      chk("t6_no_restart", start_cnt - s0, 0);
      chk("t6_select_held", int'(core_select_o), 3);
      chk("t6_still_stream", int'(in_px_ready_o), 1);
      do_abort();
      exp_q.delete();

      // Abort after 5 accepted pixels, then a clean frame.
      start_frame(2'b10);
      tick();
      in_px_valid_i = 1'b1;
      repeat (5) tick();
      in_px_valid_i = 1'b0;
      chk("t5_row_after5", int'(row_o), 1);
      chk("t5_col_after5", int'(col_o), 1);
      d0 = done_cnt;
      do_abort();
      chk("t5_abort_busy", int'(busy_o), 0);
      chk("t5_abort_row", int'(row_o), 0);
      chk("t5_abort_col", int'(col_o), 0);
      chk("t5_abort_ready", int'(in_px_ready_o), 0);
      repeat (3) tick();
      chk("t5_no_done", done_cnt - d0, 0);
      h0 = hs_cnt;
      run_frame(2'b01, 1'b1, LAT + 1, "t5b");
      chk("t5b_handshakes", hs_cnt - h0, TOTAL);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish by 200000ns");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
